debounced_switches_to_leds: RTL

Parametrised successor to the direct switch-to-LED path on the Go Board (iCE40, 25 MHz). Takes NUM_CH raw switch inputs and synchronises and debounces each channel independently. Drives one LED per channel, either following the debounced switch (pass-through mode) or toggling on each release (toggle mode, selected at run time). Also emits single-cycle press/release strobes for downstream logic.

---
 rtl/switches_pkg.sv | 16 +
 rtl/debounce_filter.sv | 56 +++++
 rtl/debounced_switches_to_leds.sv | 68 ++++++
 3 files changed

// File: rtl/switches_pkg.sv
// Shared constants, mode encoding and cycle-count helper for the switch/LED debounce block.
package switches_pkg;

    localparam int CLK_HZ              = 25_000_000;
    localparam int DEBOUNCE_MS_DEFAULT = 10;

    typedef enum logic {
        MODE_PASS   = 1'b0,
        MODE_TOGGLE = 1'b1
    } mode_e;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// One switch channel: input synchroniser, stability counter, accepted level and edge strobes.
module debounce_filter
    import switches_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = ms_to_cycles(DEBOUNCE_MS_DEFAULT),
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic switch_raw,
    output logic stable_r,
    output logic press_r,
    output logic release_r
);

    localparam int             CW       = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(DEBOUNCE_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          count_r;
    logic                   sync_s;
    logic                   accept_s;

    // Pick the synchronised level and decide whether it has been stable long enough.
    always_comb begin
        sync_s   = sync_r[SYNC_STAGES-1];
        accept_s = (sync_s != stable_r) && (count_r == LAST_CNT);
    end

    // Synchroniser shift, stability counter and accepted level with its strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r    <= {SYNC_STAGES{1'b0}};
            count_r   <= {CW{1'b0}};
            stable_r  <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], switch_raw};
            press_r   <= 1'b0;
            release_r <= 1'b0;
            // Any return to the accepted level restarts the count, so short glitches never land.
            if (sync_s == stable_r) begin
                count_r <= {CW{1'b0}};
            end else if (accept_s) begin
                stable_r  <= sync_s;
                count_r   <= {CW{1'b0}};
                press_r   <= sync_s;
                release_r <= ~sync_s;
            end else begin
                count_r <= count_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/debounced_switches_to_leds.sv
// Per-channel debounced switches driving LEDs, either following the switch or toggling on release.
module debounced_switches_to_leds
    import switches_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = ms_to_cycles(DEBOUNCE_MS_DEFAULT),
    parameter int SYNC_STAGES    = 2
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Switch,
    input  logic              i_Toggle_Mode,
    output logic [NUM_CH-1:0] o_LED,
    output logic [NUM_CH-1:0] o_Press,
    output logic [NUM_CH-1:0] o_Release
);

    logic [NUM_CH-1:0] stable_s;
    logic [NUM_CH-1:0] press_s;
    logic [NUM_CH-1:0] release_s;
    logic [NUM_CH-1:0] toggle_r;
    logic [NUM_CH-1:0] toggle_next_s;
    logic [NUM_CH-1:0] led_next_s;
    logic [NUM_CH-1:0] led_r;
    mode_e             mode_s;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_filter #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_filter (
            .clk        (i_Clk),
            .rst        (i_Rst),
            .switch_raw (i_Switch[ch]),
            .stable_r   (stable_s[ch]),
            .press_r    (press_s[ch]),
            .release_r  (release_s[ch])
        );
    end

    // Next toggle state and LED source; toggle mode shows the post-release value immediately.
    always_comb begin
        mode_s        = mode_e'(i_Toggle_Mode);
        toggle_next_s = toggle_r ^ release_s;
        led_next_s    = stable_s;
        case (mode_s)
            MODE_PASS:   led_next_s = stable_s;
            MODE_TOGGLE: led_next_s = toggle_next_s;
            default:     led_next_s = stable_s;
        endcase
    end

    // Toggle history runs in both modes so switching modes never loses it.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            toggle_r <= {NUM_CH{1'b0}};
            led_r    <= {NUM_CH{1'b0}};
        end else begin
            toggle_r <= toggle_next_s;
            led_r    <= led_next_s;
        end
    end

    assign o_LED     = led_r;
    assign o_Press   = press_s;
    assign o_Release = release_s;

endmodule
